// File: rtl/mips_hazard_unit.sv
// rtl/mips_hazard_unit.sv - hazard/forwarding controller for a 5-stage MIPS pipeline
// HAZARD_FORWARDING_EN: defined enables EX/ID forwarding; undefined stalls on any live producer.
module mips_hazard_unit #(
    parameter int REG_ADDR_W   = 5,
    parameter int BRANCH_STAGE = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  branch_taken,
    input  logic                  jump,
    output logic                  pc_hold,
    output logic                  ifid_hold,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  id_bypass_a,
    output logic                  id_bypass_b,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    if (BRANCH_STAGE != 2 && BRANCH_STAGE != 3) begin : g_bad_branch_stage
        $error("mips_hazard_unit: BRANCH_STAGE must be 2 (EX) or 3 (MEM)");
    end

    logic                  ex_valid, ex_regwrite, ex_memread;
    logic [REG_ADDR_W-1:0] ex_rd, ex_rs, ex_rt;
    logic                  mem_valid, mem_regwrite, mem_memread;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid, wb_regwrite;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic ex_live, mem_live, wb_live;
    logic id_hits_ex, id_hits_mem, id_hits_wb;
    logic stall_raw, stall, branch_flush_ex;

    assign ex_live  = ex_valid  & ex_regwrite  & (ex_rd  != '0);
    assign mem_live = mem_valid & mem_regwrite & (mem_rd != '0);
    assign wb_live  = wb_valid  & wb_regwrite  & (wb_rd  != '0);

    assign id_hits_ex  = (id_uses_rs & (id_rs == ex_rd))  | (id_uses_rt & (id_rt == ex_rd));
    assign id_hits_mem = (id_uses_rs & (id_rs == mem_rd)) | (id_uses_rt & (id_rt == mem_rd));
    assign id_hits_wb  = (id_uses_rs & (id_rs == wb_rd))  | (id_uses_rt & (id_rt == wb_rd));

`ifdef HAZARD_FORWARDING_EN
    // Only a load in EX cannot be forwarded in time; everything else is bypassed.
    assign stall_raw = id_valid & ex_valid & ex_memread & (ex_rd != '0) & id_hits_ex;

    always_comb begin
        fwd_a_sel = 2'b00;
        fwd_b_sel = 2'b00;
        if (ex_valid) begin
            if (mem_live && !mem_memread && (mem_rd == ex_rs))
                fwd_a_sel = 2'b10;
            else if (wb_live && (wb_rd == ex_rs))
                fwd_a_sel = 2'b01;
            if (mem_live && !mem_memread && (mem_rd == ex_rt))
                fwd_b_sel = 2'b10;
            else if (wb_live && (wb_rd == ex_rt))
                fwd_b_sel = 2'b01;
        end
    end

    assign id_bypass_a = wb_live & id_uses_rs & (wb_rd == id_rs);
    assign id_bypass_b = wb_live & id_uses_rt & (wb_rd == id_rt);
`else
    // Without bypass paths the consumer waits until the producer has left WB.
    assign stall_raw = id_valid & ((ex_live  & id_hits_ex)  |
                                   (mem_live & id_hits_mem) |
                                   (wb_live  & id_hits_wb));

    assign fwd_a_sel   = 2'b00;
    assign fwd_b_sel   = 2'b00;
    assign id_bypass_a = 1'b0;
    assign id_bypass_b = 1'b0;

    logic unused_nofwd;
    assign unused_nofwd = ^{ex_rs, ex_rt, ex_memread, mem_memread};
`endif

    // A taken branch squashes the dependent instruction, so the stall is moot.
    assign stall           = stall_raw & ~branch_taken;
    assign branch_flush_ex = branch_taken & (BRANCH_STAGE == 3);

    assign pc_hold   = stall;
    assign ifid_hold = stall;
    assign flush_id  = branch_taken | (jump & id_valid & ~stall);
    assign flush_ex  = stall | branch_flush_ex;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid    <= 1'b0;
            mem_valid   <= 1'b0;
            wb_valid    <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            ex_valid     <= id_valid & ~flush_ex;
            ex_regwrite  <= id_regwrite;
            ex_memread   <= id_memread;
            ex_rd        <= id_rd;
            ex_rs        <= id_rs;
            ex_rt        <= id_rt;

            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_memread  <= ex_memread;
            mem_rd       <= ex_rd;

            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;

            if (stall && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (flush_id && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_hazard_unit.sv
// tb/tb_mips_hazard_unit.sv - directed self-checking bench for mips_hazard_unit
module tb_mips_hazard_unit;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Stall cycles caused by one adjacent producer/consumer pair.
    localparam int SPL = FWD ? 1 : 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       branch_taken, jump;

    logic        m_pc_hold, m_ifid_hold, m_flush_id, m_flush_ex, m_byp_a, m_byp_b;
    logic [1:0]  m_fwd_a, m_fwd_b;
    logic [15:0] m_stall_count, m_flush_count;

    logic        s_pc_hold, s_ifid_hold, s_flush_id, s_flush_ex, s_byp_a, s_byp_b;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_count, s_flush_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_hazard_unit #(.REG_ADDR_W(5), .BRANCH_STAGE(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .jump(jump),
        .pc_hold(m_pc_hold), .ifid_hold(m_ifid_hold), .flush_id(m_flush_id), .flush_ex(m_flush_ex),
        .fwd_a_sel(m_fwd_a), .fwd_b_sel(m_fwd_b), .id_bypass_a(m_byp_a), .id_bypass_b(m_byp_b),
        .stall_count(m_stall_count), .flush_count(m_flush_count)
    );

    mips_hazard_unit #(.REG_ADDR_W(5), .BRANCH_STAGE(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .branch_taken(branch_taken), .jump(jump),
        .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .flush_id(s_flush_id), .flush_ex(s_flush_ex),
        .fwd_a_sel(s_fwd_a), .fwd_b_sel(s_fwd_b), .id_bypass_a(s_byp_a), .id_bypass_b(s_byp_b),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] rd,
                          input logic rw, input logic mr);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_uses_rs  = urs;
        id_uses_rt  = urt;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
    endtask

    task automatic nop();        set_id(1'b0, 5'd0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0); endtask
    task automatic lw8();        set_id(1'b1, 5'd9, 5'd0,  1'b1, 1'b0, 5'd8,  1'b1, 1'b1); endtask
    task automatic add8();       set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0); endtask
    task automatic add_dep();    set_id(1'b1, 5'd8, 5'd8,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0); endtask
    task automatic sub_rs8();    set_id(1'b1, 5'd8, 5'd12, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0); endtask

    task automatic drain();
        nop();
        jump         = 1'b0;
        branch_taken = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        nop();
        tick();
        tick();
        reset = 1'b1;

        // Jump counts a flush, then a load sits in EX when reset hits.
        set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        jump = 1'b1;
        #1 chk("jump_flush_id", 32'(m_flush_id), 1);
        tick();
        jump = 1'b0;
        chk("jump_flush_count", 32'(m_flush_count), 1);
        lw8();
        tick();
        add_dep();
        #1 chk("pre_reset_stall", 32'(m_pc_hold), 1);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rst_pc_hold",     32'(m_pc_hold), 0);
        chk("rst_ifid_hold",   32'(m_ifid_hold), 0);
        chk("rst_flush_id",    32'(m_flush_id), 0);
        chk("rst_flush_ex",    32'(m_flush_ex), 0);
        chk("rst_fwd_a",       32'(m_fwd_a), 0);
        chk("rst_fwd_b",       32'(m_fwd_b), 0);
        chk("rst_bypass_a",    32'(m_byp_a), 0);
        chk("rst_stall_count", 32'(m_stall_count), 0);
        chk("rst_flush_count", 32'(m_flush_count), 0);
        chk("rst_s_stall_cnt", 32'(s_stall_count), 0);
        drain();

        // Writes to $0 never create a dependency.
        set_id(1'b1, 5'd9, 5'd10, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd12, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
        #1 chk("r0_no_stall", 32'(m_pc_hold), 0);
        tick();
        chk("r0_fwd_a", 32'(m_fwd_a), 0);
        drain();

`ifdef HAZARD_FORWARDING_EN
        add8();
        tick();
        sub_rs8();
        #1 chk("alu_no_stall", 32'(m_pc_hold), 0);
        tick();
        nop();
        #1;
        chk("fwd_mem_a", 32'(m_fwd_a), 2);
        chk("fwd_mem_b", 32'(m_fwd_b), 0);
        drain();

        add8();
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd12, 5'd8, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
        tick();
        chk("fwd_wb_b",    32'(m_fwd_b), 1);
        chk("fwd_wb_a",    32'(m_fwd_a), 0);
        chk("bypass_b",    32'(m_byp_b), 1);
        chk("bypass_a",    32'(m_byp_a), 0);
        drain();

        add8();
        tick();
        add8();
        tick();
        sub_rs8();
        tick();
        chk("fwd_mem_priority", 32'(m_fwd_a), 2);
        drain();

        lw8();
        tick();
        add_dep();
        #1;
        chk("lu_pc_hold",   32'(m_pc_hold), 1);
        chk("lu_ifid_hold", 32'(m_ifid_hold), 1);
        chk("lu_flush_ex",  32'(m_flush_ex), 1);
        tick();
        chk("lu_one_cycle",  32'(m_pc_hold), 0);
        chk("lu_stall_cnt",  32'(m_stall_count), 1);
        tick();
        nop();
        #1;
        chk("lu_fwd_a", 32'(m_fwd_a), 1);
        chk("lu_fwd_b", 32'(m_fwd_b), 1);
        drain();
`else
        add8();
        tick();
        sub_rs8();
        #1 chk("nf_stall1", 32'(m_pc_hold), 1);
        tick();
        chk("nf_stall2", 32'(m_pc_hold), 1);
        chk("nf_fwd_a",  32'(m_fwd_a), 0);
        tick();
        chk("nf_stall3", 32'(m_pc_hold), 1);
        chk("nf_bypass", 32'(m_byp_a), 0);
        tick();
        chk("nf_release",   32'(m_pc_hold), 0);
        chk("nf_stall_cnt", 32'(m_stall_count), 3);
        tick();
        drain();
`endif

        // Taken branch while a load-use stall is pending.
        lw8();
        tick();
        add_dep();
        #1 chk("br_pre_stall", 32'(m_pc_hold), 1);
        branch_taken = 1'b1;
        #1;
        chk("br_pc_hold",    32'(m_pc_hold), 0);
        chk("br_ifid_hold",  32'(m_ifid_hold), 0);
        chk("br_flush_id",   32'(m_flush_id), 1);
        chk("br_flush_ex",   32'(m_flush_ex), 1);
        chk("br2_flush_ex",  32'(s_flush_ex), 0);
        chk("br2_flush_id",  32'(s_flush_id), 1);
        tick();
        branch_taken = 1'b0;
        nop();
        #1;
        chk("br_flush_count", 32'(m_flush_count), 1);
        chk("br_stall_count", 32'(m_stall_count), SPL);
        chk("br2_memread_guard_a", 32'(s_fwd_a), 0);
        chk("br2_memread_guard_b", 32'(s_fwd_b), 0);
        drain();

        // Stall and jump together: the jump flush waits for the stall to clear.
        lw8();
        tick();
        add_dep();
        jump = 1'b1;
        #1;
        chk("sj_flush_id", 32'(m_flush_id), 0);
        chk("sj_pc_hold",  32'(m_pc_hold), 1);
        tick();
        repeat (SPL - 1) tick();
        chk("sj_deferred_flush", 32'(m_flush_id), 1);
        chk("sj_released",       32'(m_pc_hold), 0);
        tick();
        jump = 1'b0;
        drain();

        for (int i = 0; i < 5; i++) begin
            lw8();
            tick();
            add_dep();
            repeat (SPL) tick();
            tick();
            drain();
        end
        chk("sat_stall_count",  32'(s_stall_count), 3);
        chk("main_stall_count", 32'(m_stall_count), 7 * SPL);
        chk("main_flush_count", 32'(m_flush_count), 2);
        chk("sat_flush_count",  32'(s_flush_count), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
